// File: rtl/sha256_pkg.sv
// Shared types and sizing for the SHA-256 message schedule stage.
package sha256_pkg;
  localparam int unsigned SHA256_BLOCK_WORDS = 16;
  localparam int unsigned SHA256_ROUNDS      = 64;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned LOAD_CNT_W         = $clog2(SHA256_BLOCK_WORDS);
  localparam int unsigned IDX_W              = $clog2(SHA256_ROUNDS);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_e;
endpackage

// File: rtl/sha256_low_sigma.sv
// SHA-256 small sigma functions used by the message schedule recurrence.
module low_sigma_0_func
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

module low_sigma_1_func
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

// File: rtl/sha256_sched_next_word.sv
// Combinational next schedule word from the current 16-word window taps.
module sha256_sched_next_word
  import sha256_pkg::*;
(
  input  word_t win0,
  input  word_t win1,
  input  word_t win9,
  input  word_t win14,
  output word_t nxt
);
  word_t s0;
  word_t s1;

  low_sigma_0_func u_sigma0 (.x(win1),  .y(s0));
  low_sigma_1_func u_sigma1 (.x(win14), .y(s1));

  // Modulo-2^32 sum; carries out of bit 31 are dropped by the word width.
  assign nxt = s1 + win9 + s0 + win0;
endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] with valid/ready.
// Optional synchronous abort input when SHA256_SCHED_ABORT_EN is defined.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [31:0]      w_word,
  output logic [IDX_W-1:0] w_idx,
  output logic             w_last,
  output logic             busy
);
  localparam int unsigned NUM_IN_WORDS  = SHA256_BLOCK_WORDS;
  localparam int unsigned NUM_OUT_WORDS = SHA256_ROUNDS;

  sched_state_e          state_q, state_d;
  logic [LOAD_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      t_q, t_d;
  word_t                 win_q [NUM_IN_WORDS];
  word_t                 win_d [NUM_IN_WORDS];
  logic                  in_ready_q, in_ready_d;
  logic                  w_valid_q, w_valid_d;
  logic                  w_last_q, w_last_d;
  logic                  busy_q, busy_d;
  word_t                 nxt;
  logic                  in_hs;
  logic                  w_hs;
  logic                  abort_req;

`ifdef SHA256_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  sha256_sched_next_word u_next (
    .win0  (win_q[0]),
    .win1  (win_q[1]),
    .win9  (win_q[9]),
    .win14 (win_q[14]),
    .nxt   (nxt)
  );

  assign in_hs = in_valid && in_ready_q;
  assign w_hs  = w_valid_q && w_ready;

  // Next-state, window shift and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    for (int i = 0; i < int'(NUM_IN_WORDS); i++) win_d[i] = win_q[i];

    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          for (int i = 0; i < int'(NUM_IN_WORDS) - 1; i++) win_d[i] = win_q[i+1];
          win_d[NUM_IN_WORDS-1] = in_word;
          cnt_d = cnt_q + LOAD_CNT_W'(1);
          if (cnt_q == LOAD_CNT_W'(NUM_IN_WORDS - 1)) state_d = EMIT;
        end
      end
      EMIT: begin
        if (w_hs) begin
          for (int i = 0; i < int'(NUM_IN_WORDS) - 1; i++) win_d[i] = win_q[i+1];
          win_d[NUM_IN_WORDS-1] = nxt;
          t_d = t_q + IDX_W'(1);
          if (t_q == IDX_W'(NUM_OUT_WORDS - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
            t_d     = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Abort wins over a coincident handshake: nothing is consumed.
    if (abort_req) begin
      state_d = LOAD;
      cnt_d   = '0;
      t_d     = '0;
      for (int i = 0; i < int'(NUM_IN_WORDS); i++) win_d[i] = win_q[i];
    end

    in_ready_d = (state_d == LOAD);
    w_valid_d  = (state_d == EMIT);
    busy_d     = (state_d == EMIT);
    w_last_d   = (state_d == EMIT) && (t_d == IDX_W'(NUM_OUT_WORDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      t_q        <= '0;
      for (int i = 0; i < int'(NUM_IN_WORDS); i++) win_q[i] <= '0;
      in_ready_q <= 1'b1;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      for (int i = 0; i < int'(NUM_IN_WORDS); i++) win_q[i] <= win_d[i];
      in_ready_q <= in_ready_d;
      w_valid_q  <= w_valid_d;
      w_last_q   <= w_last_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign w_valid  = w_valid_q;
  assign w_word   = win_q[0];
  assign w_idx    = t_q;
  assign w_last   = w_last_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a FIPS-style W[t] model.
module tb_sha256_msg_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  int          exp_idx = 0;
  bit          stalled = 0;
  logic [31:0] prev_word;
  logic [5:0]  prev_idx;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef SHA256_SCHED_ABORT_EN
    .abort    (abort),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Textbook expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_w_valid"},  w_valid, 0);
    check({tag, "_w_word"},   w_word, 0);
    check({tag, "_w_idx"},    w_idx, 0);
    check({tag, "_w_last"},   w_last, 0);
    check({tag, "_busy"},     busy, 0);
  endtask

  // Compare process: every cycle an output word is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      stalled = 0;
    end else if (w_valid) begin
      check("w_idx", w_idx, exp_idx);
      check("w_word", w_word, exp_w[exp_idx]);
      check("w_last", w_last, (exp_idx == 63));
      check("busy", busy, 1);
      check("in_ready_emit", in_ready, 0);
      if (stalled) begin
        check("stall_word", w_word, prev_word);
        check("stall_idx", w_idx, prev_idx);
      end
      if (abort === 1'b1) begin
        exp_idx = 0;
        stalled = 0;
      end else if (w_ready) begin
        exp_idx = (exp_idx + 1) % 64;
        stalled = 0;
      end else begin
        stalled   = 1;
        prev_word = w_word;
        prev_idx  = w_idx;
      end
    end else begin
      check("w_last_idle", w_last, 0);
      stalled = 0;
    end
  end

  task automatic load_block(input int gap_at);
    bit hs;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
      end
      in_valid = 1;
      in_word  = blk[i];
      if (i == 15) check("no_valid_before_16th", w_valid, 0);
      hs = 0;
      for (int c = 0; c < 50 && !hs; c++) begin
        hs = in_ready;
        @(posedge clk);
        #1;
      end
      if (!hs) check("load_timeout", 0, 1);
    end
    in_valid = 0;
    check("first_valid_latency", w_valid, 1);
    check("in_ready_after_load", in_ready, 0);
  endtask

  task automatic drain(input bit rnd, input int stop_idx, input int abort_idx, input bit junk);
    bit hs, last, done;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      w_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = junk;
      in_word  = $urandom;
      if (w_valid && int'(w_idx) == stop_idx) begin
        in_valid = 0;
        rst_n = 0;
        #1;
        check_reset_outputs("rst_mid_emit");
        @(posedge clk);
        #1;
        rst_n = 1;
        done = 1;
      end else if (w_valid && int'(w_idx) == abort_idx) begin
        in_valid = 0;
        w_ready  = 1;
        abort    = 1;
        @(posedge clk);
        #1;
        abort = 0;
        check("abort_w_valid", w_valid, 0);
        check("abort_in_ready", in_ready, 1);
        done = 1;
      end else begin
        hs   = w_valid && w_ready;
        last = w_last;
        @(posedge clk);
        #1;
        if (hs && last) begin
          check("post_last_in_ready", in_ready, 1);
          check("post_last_w_valid", w_valid, 0);
          check("post_last_busy", busy, 0);
          done = 1;
        end
      end
    end
    in_valid = 0;
    w_ready  = 0;
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    rst_n    = 0;
    abort    = 0;
    in_valid = 0;
    in_word  = 0;
    w_ready  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk);
    #1;

    // "abc" block, no stalls, junk on in_valid during emit.
    set_abc();
    check("model_W0", exp_w[0], 32'h61626380);
    check("model_W15", exp_w[15], 32'h00000018);
    check("model_W16", exp_w[16], 32'h61626380);
    check("model_W17", exp_w[17], 32'h000F0000);
    load_block(-1);
    drain(0, -1, -1, 1);

    // Same block with random backpressure.
    load_block(-1);
    drain(1, -1, -1, 0);

    // Idle gap between words 7 and 8.
    load_block(8);
    drain(0, -1, -1, 0);

    // All-ones block directly after.
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_model();
    check("model_ones_W16", exp_w[16], 32'h203FFFFC);
    load_block(-1);
    drain(1, -1, -1, 0);

    // Reset mid-emit at t=30, then a fresh "abc" run.
    set_abc();
    load_block(-1);
    drain(0, 30, -1, 0);
    load_block(-1);
    drain(0, -1, -1, 0);

`ifdef SHA256_SCHED_ABORT_EN
    load_block(-1);
    drain(0, -1, 10, 0);
    load_block(-1);
    drain(1, -1, -1, 0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message schedule stage. Accepts one 512-bit block as 16 serial 32-bit words and streams W[0..63] to the downstream compression-round engine, one word per handshake.
- Sits between the block padder/loader upstream and the round datapath downstream.
- Uses the team's existing low_sigma_0_func and low_sigma_1_func for σ0/σ1.

Parameters:
- NUM_IN_WORDS, 16, words per message block (fixed by SHA-256; not for override)
- NUM_OUT_WORDS, 64, schedule words emitted per block

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_word is valid
- in_ready  out  1  block can accept a word (high only in LOAD)
- in_word  in  32  message word, big-endian word order, M[0] first
- w_valid  out  1  w_word is valid (high only in EMIT)
- w_ready  in  1  downstream accepts w_word
- w_word  out  32  schedule word W[w_idx]
- w_idx  out  6  index t of w_word, 0..63
- w_last  out  1  high with w_valid when w_idx == 63
- busy  out  1  high in EMIT

Behaviour:
- Reset (async assert, sync deassert by the clock domain): state=LOAD, load counter=0, t=0, window cleared to 0. Output reset values: in_ready=1, w_valid=0, w_word=0, w_idx=0, w_last=0, busy=0.
- Storage: 16×32 window win[0..15]. win[0] is the oldest word.
- LOAD state:
  - On in_valid&in_ready: win shifts left (win[i]<=win[i+1]), win[15]<=in_word, load counter increments.
  - On the 16th accepted word: state goes to EMIT. w_valid is high the next cycle with W[0]=M[0]. Latency from 16th handshake to first w_valid is 1 cycle.
- EMIT state:
  - w_word=win[0], w_idx=t.
  - On w_valid&w_ready: win shifts left, win[15]<=nxt, t increments.
  - nxt = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed modulo 2^32 with carries discarded.
  - The same recurrence applies for every t. Words generated after t=47 are never emitted and are don't-care.
- Handshake rules:
  - w_word and w_idx hold stable while w_valid && !w_ready.
  - No combinational path from w_ready to w_valid, or from in_valid to in_ready.
- Exit from EMIT: on the handshake with t=63, state goes to LOAD, t=0, load counter=0, in_ready=1 next cycle. There are no back-to-back overlapping blocks: in_ready=0 throughout EMIT.
- in_valid during EMIT is ignored and no word is consumed.
- Reset mid-load or mid-emit: immediate return to the reset state. Partial block is discarded.
- Throughput: 16 load cycles + 64 emit cycles minimum per block.

Optional Feature:
- Macro: SHA256_SCHED_ABORT_EN.
- With the macro: adds input port abort (1 bit). When abort=1 on a clock edge in any state, the block goes synchronously to LOAD with counter=0 and t=0, and w_valid falls the next cycle. abort has priority over a simultaneous handshake; that word is not consumed or emitted.
- Without the macro: the port does not exist and only rst_n clears the block.

Decomposition:
- sha256_pkg holds:
  - typedef logic [31:0] word_t
  - enum sched_state_e {LOAD, EMIT}
  - localparams SHA256_BLOCK_WORDS=16, SHA256_ROUNDS=64
- Sub-module sha256_sched_next_word: combinational. Inputs win[0], win[1], win[9], win[14]; output nxt. It instantiates low_sigma_0_func and low_sigma_1_func plus the 4-input adder.

Test Plan:
- "abc" block: load 0x61626380, fourteen 0x00000000, then 0x00000018 → W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000. All 64 words match the golden model, and w_last is high only at w_idx=63.
- Backpressure: random w_ready (~50%) → sequence identical to the no-stall run, and w_word/w_idx are stable whenever stalled.
- Idle gaps on input: in_valid low for 3 cycles between words 7 and 8 → same schedule. First w_valid appears exactly 1 cycle after the 16th handshake.
- Two blocks back-to-back: after the W[63] handshake, in_ready=1 the next cycle. The second block (all 0xFFFFFFFF) yields W[16]=σ1(0xFFFFFFFF)+0xFFFFFFFF+σ0(0xFFFFFFFF)+0xFFFFFFFF mod 2^32, per the golden model.
- Reset mid-emit at t=30: all outputs return to reset values. A fresh "abc" load then reproduces the first scenario exactly.
- (SHA256_SCHED_ABORT_EN) abort at t=10 coincident with a handshake → W[10] is not counted, w_valid=0 and in_ready=1 the next cycle, and the following block is correct.
